// File: rtl/ifq_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package ifq_pkg;

  localparam int IFQ_DEPTH_DEF   = 4;
  localparam int IFQ_FLUSH_CNT_W = 16;
  localparam int IFQ_PC_W_DEF    = 32;
  localparam int IFQ_INSTR_W_DEF = 32;

  typedef struct packed {
    logic [IFQ_PC_W_DEF-1:0]    pc;
    logic [IFQ_INSTR_W_DEF-1:0] instruction;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_ram.sv
// Queue storage: DEPTH-entry register array, one synchronous write port, one async read port.
module ifq_ram
  import ifq_pkg::*;
#(
  parameter int  DEPTH   = IFQ_DEPTH_DEF,
  parameter type entry_t = ifq_entry_t,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  entry_t            wdata,
  input  logic [ADDR_W-1:0] raddr,
  output entry_t            rdata
);

  entry_t mem [DEPTH];

  // Contents are deliberately left unreset; validity is tracked by the controller.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue with freeze back-pressure and branch flush.
// Optional feature: define IFQ_STATS_EN to add the saturating flush_count output.
module if_id_queue
  import ifq_pkg::*;
#(
  parameter int DEPTH   = IFQ_DEPTH_DEF,
  parameter int PC_W    = IFQ_PC_W_DEF,
  parameter int INSTR_W = IFQ_INSTR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid,
  input  logic [PC_W-1:0]            if_pc,
  input  logic [INSTR_W-1:0]         if_instruction,
  output logic                       if_freeze,
  input  logic                       flush,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [PC_W-1:0]            id_pc,
  output logic [INSTR_W-1:0]         id_instruction
`ifdef IFQ_STATS_EN
  ,
  output logic [IFQ_FLUSH_CNT_W-1:0] flush_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instruction;
  } entry_t;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  entry_t           wr_entry;
  entry_t           rd_entry;

  // Freeze is a pure decode of the registered count, so a pop while full
  // still blocks the push in that same cycle.
  assign if_freeze = (count == FULL_CNT);
  assign id_valid  = (count != '0);
  assign push      = if_valid & ~if_freeze & ~flush;
  assign pop       = id_valid & id_ready & ~flush;

  assign wr_entry.pc          = if_pc;
  assign wr_entry.instruction = if_instruction;

  ifq_ram #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Stale array contents must not leak out while the queue is empty.
  assign id_pc          = id_valid ? rd_entry.pc          : '0;
  assign id_instruction = id_valid ? rd_entry.instruction : '0;

`ifdef IFQ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_count <= '0;
    end else if (flush && (flush_count != '1)) begin
      flush_count <= flush_count + IFQ_FLUSH_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: queue-based reference model, directed scenarios, random traffic.
module tb_if_id_queue;

  localparam int DEPTH   = 4;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               if_valid = 1'b0;
  logic [PC_W-1:0]    if_pc = '0;
  logic [INSTR_W-1:0] if_instruction = '0;
  logic               flush = 1'b0;
  logic               id_ready = 1'b0;
  logic               if_freeze;
  logic               id_valid;
  logic [PC_W-1:0]    id_pc;
  logic [INSTR_W-1:0] id_instruction;
`ifdef IFQ_STATS_EN
  logic [15:0]        flush_count;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  bit          check_en = 1'b0;
  logic [63:0] mq[$];
  int          model_flushes = 0;

  always #5 clk = ~clk;

  if_id_queue #(
    .DEPTH   (DEPTH),
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .if_freeze      (if_freeze),
    .flush          (flush),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instruction (id_instruction)
`ifdef IFQ_STATS_EN
    ,
    .flush_count    (flush_count)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return at the following negedge.
  task automatic applyStimulus(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                               input bit fl, input bit rdy);
    bit full;
    bit do_push;
    bit do_pop;
    if_valid = v;
    if_pc = pc;
    if_instruction = ins;
    flush = fl;
    id_ready = rdy;
    @(posedge clk);
    full = (mq.size() == DEPTH);
    if (fl) begin
      mq.delete();
      if (model_flushes < 65535) model_flushes++;
    end else begin
      do_pop = (mq.size() != 0) && rdy;
      do_push = v && !full;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({pc, ins});
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    check_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_id_valid", id_valid, 0);
    checkOutput("rst_if_freeze", if_freeze, 0);
    checkOutput("rst_id_pc", id_pc, 0);
    checkOutput("rst_id_instr", id_instruction, 0);
    mq.delete();
    model_flushes = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_en = 1'b1;
  endtask

  // Cycle-by-cycle comparison of the DUT against the reference model.
  always @(negedge clk) begin
    if (check_en) begin
      logic [63:0] head;
      bit          exp_valid;
      exp_valid = (mq.size() != 0);
      head = exp_valid ? mq[0] : 64'd0;
      checkOutput("id_valid", id_valid, exp_valid);
      checkOutput("id_pc", id_pc, head[63:32]);
      checkOutput("id_instruction", id_instruction, head[31:0]);
      checkOutput("if_freeze", if_freeze, mq.size() == DEPTH);
`ifdef IFQ_STATS_EN
      checkOutput("flush_count", flush_count, model_flushes);
`endif
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check_en = 1'b1;

    // Reset mid-run with three entries queued.
    for (int i = 1; i <= 3; i++) applyStimulus(1, 32'h40 + 4 * i, 32'hA0 + i, 0, 0);
    checkOutput("pre_rst_valid", id_valid, 1);
    doReset();

    // Fill to full with decode stalled; a fifth fetch is refused.
    for (int i = 1; i <= 4; i++) applyStimulus(1, 4 * i, 32'hC000 + i, 0, 0);
    checkOutput("fill_freeze", if_freeze, 1);
    applyStimulus(1, 20, 32'hC005, 0, 0);
    checkOutput("fill_still_frozen", if_freeze, 1);
    checkOutput("fill_head", id_pc, 4);

    // Drain in FIFO order.
    for (int i = 1; i <= 4; i++) begin
      checkOutput("drain_pc", id_pc, 4 * i);
      applyStimulus(0, 0, 0, 0, 1);
      if (i == 1) checkOutput("drain_freeze_drop", if_freeze, 0);
    end
    checkOutput("drain_empty", id_valid, 0);

    // Continuous streaming keeps one entry resident.
    for (int pc = 4; pc <= 40; pc += 4) begin
      applyStimulus(1, pc, ~pc, 0, 1);
      checkOutput("stream_pc", id_pc, pc);
      checkOutput("stream_nofreeze", if_freeze, 0);
    end
    applyStimulus(0, 0, 0, 0, 1);

    // Flush with three entries and a concurrent fetch.
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'h100 + 4 * i, 32'hD0 + i, 0, 0);
    applyStimulus(1, 32'h999, 32'hDEAD, 1, 1);
    checkOutput("flush_valid", id_valid, 0);
    applyStimulus(1, 32'h200, 32'hE0, 0, 0);
    checkOutput("post_flush_head", id_pc, 32'h200);
    applyStimulus(1, 32'h204, 32'hE1, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);

    // Flush while full releases freeze next cycle.
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'h300 + 4 * i, i, 0, 0);
    checkOutput("full_before_flush", if_freeze, 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("full_flush_freeze", if_freeze, 0);

    // Wrap-around with two flushes.
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 32'h1000 + 4 * i, 32'hF00 + i, 0, (i % 3) != 0);
      if (i == 4 || i == 8) applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, (i % 2) == 0);
    end
`ifdef IFQ_STATS_EN
    checkOutput("stats_two_flushes", flush_count, 2);
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom,
                    $urandom_range(0, 31) == 0,
                    (n % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
